// File: rtl/dmu_sii_req_tx_if.sv
// DMU core <-> SII request packetizer bundle: request handshake, payload buffer
// port, SII request bus and write-ack/credit signals.
interface dmu_sii_req_tx_if;
    logic         req_vld;
    logic         req_rdy;
    logic [1:0]   req_type;
    logic         req_bypass;
    logic [127:0] req_hdr;

    logic         pay_rd;
    logic [127:0] pay_data;
    logic [15:0]  pay_be;

    logic         dmu_sii_hdr_vld;
    logic         dmu_sii_reqbypass;
    logic         dmu_sii_datareq;
    logic         dmu_sii_datareq16;
    logic [127:0] dmu_sii_data;
    logic [7:0]   dmu_sii_parity;
    logic [15:0]  dmu_sii_be;

    logic         sii_dmu_wrack_vld;
    logic [3:0]   sii_dmu_wrack_tag;
    logic [4:0]   wr_credits_avail;
    logic         wrack_err;

    // Core / buffer / SII-ack side.
    modport master (
        output req_vld, req_type, req_bypass, req_hdr,
        output pay_data, pay_be,
        output sii_dmu_wrack_vld, sii_dmu_wrack_tag,
        input  req_rdy, pay_rd,
        input  dmu_sii_hdr_vld, dmu_sii_reqbypass, dmu_sii_datareq, dmu_sii_datareq16,
        input  dmu_sii_data, dmu_sii_parity, dmu_sii_be,
        input  wr_credits_avail, wrack_err
    );

    // Packetizer side.
    modport slave (
        input  req_vld, req_type, req_bypass, req_hdr,
        input  pay_data, pay_be,
        input  sii_dmu_wrack_vld, sii_dmu_wrack_tag,
        output req_rdy, pay_rd,
        output dmu_sii_hdr_vld, dmu_sii_reqbypass, dmu_sii_datareq, dmu_sii_datareq16,
        output dmu_sii_data, dmu_sii_parity, dmu_sii_be,
        output wr_credits_avail, wrack_err
    );
endinterface

// File: rtl/dmu_sii_req_tx.sv
// DMU->SII request packetizer: header cycle, payload beats fetched from a
// synchronous-read buffer, per-16b parity, and the DMA write tag/credit pool.
module dmu_sii_req_tx #(
    parameter int unsigned WR_CREDITS = 16,
    parameter int unsigned WR_BEATS   = 4
) (
    input  logic            iol2clk,
    input  logic            rst,
    dmu_sii_req_tx_if.slave bus,
    output logic [1:0]      fsm_state_o
);
    localparam int unsigned BEAT_W = (WR_BEATS > 1) ? $clog2(WR_BEATS) : 1;
    localparam logic [1:0]  T_RD   = 2'b00;
    localparam logic [1:0]  T_WR   = 2'b01;
    localparam logic [1:0]  T_MON  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [BEAT_W-1:0]       last_q, last_d;
    logic                    hdr_vld_q, hdr_vld_d;
    logic                    bypass_q, bypass_d;
    logic                    datareq_q, datareq_d;
    logic                    datareq16_q, datareq16_d;
    logic [127:0]            hdr_q, hdr_d;
    logic                    pay_rd_q, pay_rd_d;
    logic [WR_CREDITS-1:0]   tags_q, tags_d;
    logic [4:0]              credits_q, credits_d;
    logic                    wrack_err_q, wrack_err_d;

    logic                    can_take;
    logic                    req_rdy;
    logic                    accept;
    logic                    is_write;
    logic                    tag_free;
    logic [3:0]              free_tag;
    logic [127:0]            hdr_img;
    logic [WR_CREDITS-1:0]   ack_mask;
    logic [WR_CREDITS-1:0]   alloc_mask;
    logic                    ack_hit;
    logic [4:0]              pop;
    logic                    in_pay;
    logic [127:0]            data_out;
    logic [7:0]              parity;

    // Lowest-index free tag; descending scan so the last hit is the lowest.
    always_comb begin
        free_tag = '0;
        tag_free = 1'b0;
        for (int i = int'(WR_CREDITS) - 1; i >= 0; i--) begin
            if (!tags_q[i]) begin
                free_tag = 4'(i);
                tag_free = 1'b1;
            end
        end
    end

    // Handshake: a request is taken on the rising edge where req_vld && req_rdy.
    // req_rdy depends only on FSM state, the write tag pool and req_type, never
    // on anything downstream, and a stalled write blocks everything behind it.
    always_comb begin
        can_take = 1'b0;
        case (state_q)
            ST_IDLE: can_take = 1'b1;
            ST_HDR:  can_take = !datareq_q;
            ST_PAY:  can_take = (beat_q == last_q);
            default: can_take = 1'b0;
        endcase
        is_write = (bus.req_type == T_WR);
        req_rdy  = can_take && (!is_write || tag_free);
        accept   = bus.req_vld && req_rdy;
    end

    always_comb begin
        hdr_img = bus.req_hdr;
        if (is_write) begin
            hdr_img[75:72] = free_tag;
        end
    end

    // Tag pool: freeing and allocating in the same cycle touch different bits.
    always_comb begin
        ack_mask   = '0;
        alloc_mask = '0;
        for (int i = 0; i < int'(WR_CREDITS); i++) begin
            ack_mask[i]   = bus.sii_dmu_wrack_vld && (bus.sii_dmu_wrack_tag == 4'(i));
            alloc_mask[i] = accept && is_write && (free_tag == 4'(i));
        end
        ack_hit     = |(ack_mask & tags_q);
        wrack_err_d = bus.sii_dmu_wrack_vld && !ack_hit;
        tags_d      = (tags_q & ~ack_mask) | alloc_mask;
        pop         = '0;
        for (int i = 0; i < int'(WR_CREDITS); i++) begin
            pop = pop + 5'(tags_d[i]);
        end
        credits_d = 5'(WR_CREDITS) - pop;
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        last_d      = last_q;
        hdr_vld_d   = 1'b0;
        bypass_d    = 1'b0;
        datareq_d   = 1'b0;
        datareq16_d = 1'b0;
        hdr_d       = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_HDR;
            end
            ST_HDR: begin
                if (datareq_q) begin
                    state_d = ST_PAY;
                    beat_d  = '0;
                end else begin
                    state_d = accept ? ST_HDR : ST_IDLE;
                end
            end
            ST_PAY: begin
                if (beat_q == last_q) begin
                    state_d = accept ? ST_HDR : ST_IDLE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            hdr_vld_d = 1'b1;
            hdr_d     = hdr_img;
            case (bus.req_type)
                T_RD: begin
                    bypass_d = bus.req_bypass;
                    last_d   = '0;
                end
                T_WR: begin
                    datareq_d = 1'b1;
                    bypass_d  = bus.req_bypass;
                    last_d    = BEAT_W'(WR_BEATS - 1);
                end
                T_MON: begin
                    datareq_d   = 1'b1;
                    datareq16_d = 1'b1;
                    last_d      = '0;
                end
                default: begin
                    datareq_d   = 1'b1;
                    datareq16_d = 1'b1;
                    bypass_d    = 1'b1;
                    last_d      = '0;
                end
            endcase
        end

        // pay_rd leads each payload cycle by one: the header cycle and all but the last beat.
        pay_rd_d = (state_d == ST_HDR && datareq_d) ||
                   (state_d == ST_PAY && beat_d != last_q);
    end

    always_ff @(posedge iol2clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            last_q      <= '0;
            hdr_vld_q   <= 1'b0;
            bypass_q    <= 1'b0;
            datareq_q   <= 1'b0;
            datareq16_q <= 1'b0;
            hdr_q       <= '0;
            pay_rd_q    <= 1'b0;
            tags_q      <= '0;
            credits_q   <= 5'(WR_CREDITS);
            wrack_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            last_q      <= last_d;
            hdr_vld_q   <= hdr_vld_d;
            bypass_q    <= bypass_d;
            datareq_q   <= datareq_d;
            datareq16_q <= datareq16_d;
            hdr_q       <= hdr_d;
            pay_rd_q    <= pay_rd_d;
            tags_q      <= tags_d;
            credits_q   <= credits_d;
            wrack_err_q <= wrack_err_d;
        end
    end

    // Payload beats come straight from the buffer's output register, so a beat
    // lands in the cycle right after its pay_rd; outside PAY the mux shows hdr_q.
    always_comb begin
        in_pay   = (state_q == ST_PAY);
        data_out = in_pay ? bus.pay_data : hdr_q;
        for (int i = 0; i < 8; i++) begin
            parity[i] = ^data_out[16*i +: 16];
        end
    end

    assign bus.req_rdy           = req_rdy;
    assign bus.pay_rd            = pay_rd_q;
    assign bus.dmu_sii_hdr_vld   = hdr_vld_q;
    assign bus.dmu_sii_reqbypass = bypass_q;
    assign bus.dmu_sii_datareq   = datareq_q;
    assign bus.dmu_sii_datareq16 = datareq16_q;
    assign bus.dmu_sii_data      = data_out;
    assign bus.dmu_sii_parity    = parity;
    assign bus.dmu_sii_be        = in_pay ? bus.pay_be : 16'h0000;
    assign bus.wr_credits_avail  = credits_q;
    assign bus.wrack_err         = wrack_err_q;
    assign fsm_state_o           = state_q;
endmodule

// File: tb/tb_dmu_sii_req_tx.sv
// Bench for dmu_sii_req_tx: drives requests/acks, models the payload buffer and
// tag pool, and checks every output cycle against an expected queue.
module tb_dmu_sii_req_tx;
  localparam int WR_CREDITS = 16;
  localparam int WR_BEATS   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmu_sii_req_tx_if bus();
  logic [1:0] fsm_state;

  dmu_sii_req_tx #(.WR_CREDITS(WR_CREDITS), .WR_BEATS(WR_BEATS)) dut (
    .iol2clk     (clk),
    .rst         (rst),
    .bus         (bus),
    .fsm_state_o (fsm_state)
  );

  typedef struct packed {
    logic [31:0]  cyc;
    logic         hv;
    logic         byp;
    logic         dr;
    logic         dr16;
    logic [127:0] data;
    logic [15:0]  be;
  } exp_t;

  exp_t         exp_q[$];
  logic [31:0]  prd_q[$];
  logic [143:0] stage_q[$];
  logic [143:0] buf_q[$];

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] cyc = 0;
  logic [15:0] mbm = '0;
  logic        exp_err = 1'b0;
  logic        rd_pending = 1'b0;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] par16(input logic [127:0] d);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 128; i++) p[i/16] = p[i/16] ^ d[i];
    return p;
  endfunction

  function automatic int popc(input logic [15:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- clock / cycle counter ----------------
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- payload buffer model (synchronous read) ----------------
  always @(posedge clk) begin
    logic rd;
    rd = rd_pending;
    #1;
    if (rd && buf_q.size() > 0) begin
      {bus.pay_be, bus.pay_data} = buf_q.pop_front();
    end else begin
      bus.pay_data = rand128();
      bus.pay_be   = 16'($urandom);
    end
  end

  // ---------------- monitor + scoreboard + reference model ----------------
  always @(negedge clk) begin
    exp_t        obs, e, h;
    logic        exp_prd, nerr, found;
    logic [15:0] nbm;
    logic [3:0]  tag;
    logic [127:0] hdr;
    logic [143:0] s;
    int          k;
    obs.cyc  = cyc;
    obs.hv   = bus.dmu_sii_hdr_vld;
    obs.byp  = bus.dmu_sii_reqbypass;
    obs.dr   = bus.dmu_sii_datareq;
    obs.dr16 = bus.dmu_sii_datareq16;
    obs.data = bus.dmu_sii_data;
    obs.be   = bus.dmu_sii_be;
    if (rst) begin
      exp_q.delete();
      prd_q.delete();
      buf_q.delete();
      mbm        = '0;
      exp_err    = 1'b0;
      rd_pending = 1'b0;
      check_val("rst_outputs", {bus.pay_rd, bus.dmu_sii_parity, bus.wrack_err, obs.hv, obs.byp,
                                obs.dr, obs.dr16, obs.data, obs.be}, '0);
      check_val("rst_credits", bus.wr_credits_avail, 16);
    end else begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
      end else begin
        e = '0;
        e.cyc = cyc;
      end
      check_val("out_beat", obs, e);
      check_val("parity", bus.dmu_sii_parity, par16(e.data));
      exp_prd = (prd_q.size() > 0 && prd_q[0] == cyc);
      if (exp_prd) void'(prd_q.pop_front());
      check_val("pay_rd", bus.pay_rd, exp_prd);
      rd_pending = bus.pay_rd;
      check_val("credits", bus.wr_credits_avail, WR_CREDITS - popc(mbm));
      check_val("wrack_err", bus.wrack_err, exp_err);

      // model the coming edge
      nbm  = mbm;
      nerr = 1'b0;
      if (bus.sii_dmu_wrack_vld) begin
        if (mbm[bus.sii_dmu_wrack_tag]) nbm[bus.sii_dmu_wrack_tag] = 1'b0;
        else nerr = 1'b1;
      end
      if (bus.req_vld && bus.req_rdy) begin
        found = 1'b0;
        tag   = '0;
        for (int i = 0; i < WR_CREDITS; i++) begin
          if (!mbm[i] && !found) begin
            tag   = 4'(i);
            found = 1'b1;
          end
        end
        hdr = bus.req_hdr;
        h   = '0;
        h.cyc = cyc + 1;
        h.hv  = 1'b1;
        k = 0;
        case (bus.req_type)
          2'b00: h.byp = bus.req_bypass;
          2'b01: begin
            if (!found) check_val("wr_accept_without_credit", 0, 1);
            hdr[75:72] = tag;
            nbm[tag]   = 1'b1;
            h.dr  = 1'b1;
            h.byp = bus.req_bypass;
            k = WR_BEATS;
          end
          2'b10: begin
            h.dr = 1'b1; h.dr16 = 1'b1; k = 1;
          end
          default: begin
            h.dr = 1'b1; h.dr16 = 1'b1; h.byp = 1'b1; k = 1;
          end
        endcase
        h.data = hdr;
        exp_q.push_back(h);
        for (int i = 0; i < k; i++) begin
          s = (stage_q.size() > 0) ? stage_q.pop_front() : '0;
          buf_q.push_back(s);
          e      = '0;
          e.cyc  = cyc + 2 + i;
          e.data = s[127:0];
          e.be   = s[143:128];
          exp_q.push_back(e);
          prd_q.push_back(cyc + 1 + i);
        end
      end
      mbm     = nbm;
      exp_err = nerr;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic stage_beat(input logic [127:0] d, input logic [15:0] be);
    stage_q.push_back({be, d});
  endtask

  task automatic send(input logic [1:0] t, input logic byp, input logic [127:0] hdr, output int acc_cyc);
    logic ok;
    int   budget;
    bus.req_type   = t;
    bus.req_bypass = byp;
    bus.req_hdr    = hdr;
    bus.req_vld    = 1'b1;
    ok      = 1'b0;
    budget  = 0;
    acc_cyc = -1;
    while (!ok && budget < 100) begin
      @(negedge clk);
      ok = bus.req_rdy;
      if (ok) acc_cyc = int'(cyc);
      @(posedge clk);
      #1;
      bus.sii_dmu_wrack_vld = 1'b0;
      budget++;
    end
    bus.req_vld = 1'b0;
    if (!ok) check_val("send_timeout", 0, 1);
  endtask

  task automatic send_write(input logic [127:0] hdr, output int acc_cyc);
    for (int i = 0; i < WR_BEATS; i++) stage_beat(rand128(), 16'($urandom));
    send(2'b01, 1'($urandom_range(0, 1)), hdr, acc_cyc);
  endtask

  task automatic ack(input logic [3:0] t);
    bus.sii_dmu_wrack_vld = 1'b1;
    bus.sii_dmu_wrack_tag = t;
    @(posedge clk);
    #1;
    bus.sii_dmu_wrack_vld = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a, b, c, t, k, budget;
    bus.req_vld           = 1'b0;
    bus.req_type          = 2'b00;
    bus.req_bypass        = 1'b0;
    bus.req_hdr           = '0;
    bus.pay_data          = '0;
    bus.pay_be            = '0;
    bus.sii_dmu_wrack_vld = 1'b0;
    bus.sii_dmu_wrack_tag = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // single bypass read
    send(2'b00, 1'b1, {4{32'hA5A5_A5A5}}, a);
    idle(3);

    // write with fixed beats
    stage_beat({16{8'h11}}, 16'hFFFF);
    stage_beat({16{8'h22}}, 16'h0F0F);
    stage_beat({16{8'h33}}, 16'hF0F0);
    stage_beat({16{8'h44}}, 16'h00FF);
    send(2'b01, 1'b0, rand128(), a);
    idle(7);
    @(negedge clk);
    check_val("credits_after_write", bus.wr_credits_avail, 15);
    @(posedge clk);
    #1;

    // back-to-back reads
    send(2'b00, 1'b0, rand128(), a);
    send(2'b00, 1'b1, rand128(), b);
    send(2'b00, 1'b0, rand128(), c);
    check_val("b2b_rd_gap1", b - a, 1);
    check_val("b2b_rd_gap2", c - b, 1);

    // mondo then PIO (bypass input ignored for mondo)
    stage_beat(rand128(), 16'($urandom));
    send(2'b10, 1'b1, rand128(), a);
    stage_beat(rand128(), 16'($urandom));
    send(2'b11, 1'b0, rand128(), b);
    check_val("mondo_pio_gap", b - a, 2);

    // write followed by read: accepted in the last payload beat
    send_write(rand128(), a);
    send(2'b00, 1'b1, rand128(), b);
    check_val("wr_rd_gap", b - a, 1 + WR_BEATS);
    idle(6);

    // ack of a tag that is not outstanding, then release tag 1
    ack(4'd9);
    idle(2);
    ack(4'd1);
    idle(1);

    // ack of tag 0 in the same cycle as a write accept
    bus.sii_dmu_wrack_vld = 1'b1;
    bus.sii_dmu_wrack_tag = 4'd0;
    send_write(rand128(), a);
    @(negedge clk);
    check_val("credits_simul_ack", bus.wr_credits_avail, 15);
    @(posedge clk);
    #1;
    idle(6);
    ack(4'd1);
    idle(2);

    // exhaust the tag pool
    for (int i = 0; i < WR_CREDITS; i++) send_write(rand128(), a);
    idle(7);
    for (int i = 0; i < WR_BEATS; i++) stage_beat(rand128(), 16'($urandom));
    bus.req_type   = 2'b01;
    bus.req_bypass = 1'b0;
    bus.req_hdr    = rand128();
    bus.req_vld    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_val("full_rdy", bus.req_rdy, 0);
      @(posedge clk);
      #1;
    end
    bus.sii_dmu_wrack_vld = 1'b1;
    bus.sii_dmu_wrack_tag = 4'd5;
    @(negedge clk);
    check_val("full_rdy_ack_cycle", bus.req_rdy, 0);
    @(posedge clk);
    #1;
    bus.sii_dmu_wrack_vld = 1'b0;
    @(negedge clk);
    check_val("rdy_after_ack", bus.req_rdy, 1);
    @(posedge clk);
    #1;
    bus.req_vld = 1'b0;
    idle(8);

    // reset during payload beat 2 of a write
    ack(4'd0);
    idle(1);
    send_write(rand128(), a);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    stage_q.delete();
    idle(2);
    send(2'b00, 1'b0, rand128(), a);
    send_write(rand128(), b);
    idle(8);

    // random mix
    for (int i = 0; i < 8; i++) begin
      t = $urandom_range(0, 3);
      k = (t == 1) ? WR_BEATS : ((t >= 2) ? 1 : 0);
      for (int j = 0; j < k; j++) stage_beat(rand128(), 16'($urandom));
      send(2'(t), 1'($urandom_range(0, 1)), rand128(), a);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    budget = 0;
    while (exp_q.size() > 0 && budget < 50) begin
      idle(1);
      budget++;
    end
    check_val("drain", exp_q.size(), 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
